key_click_decoder: RTL and testbench
====================================

Name: key_click_decoder

Overview:
Per-key click classifier placed directly downstream of the key debounce stage. Consumes the debouncer's one-cycle key event pulses and emits, per key, a one-cycle single_click or double_click pulse. A double click is two events within a programmable window. Outputs drive the mode/menu control logic; each key has an independent FSM and window counter.

Parameters:
KEY_NUM, 3, number of independent key channels
CLICK_WINDOW, 15_000_000, double-click window in clk cycles (300 ms at 50 MHz); legal range 2 .. 2^CNT_W-1
CNT_W, 24, width of each per-key window counter

Ports:
clk  input  1  system clock, 50 MHz board oscillator
rst_n  input  1  synchronous reset, active-high; the name follows the existing port naming, and the polarity is high
key_pulse  input  KEY_NUM  debounced key events, one clk cycle wide per event, bit i = key i
single_click  output  KEY_NUM  one-cycle pulse: key i clicked once, with no second event inside the window
double_click  output  KEY_NUM  one-cycle pulse: key i clicked twice inside the window
key_busy  output  KEY_NUM  high while key i is waiting in its window

Behaviour:
- One clock and one reset. All state is sampled on the rising edge of clk. Reset is checked before every other condition.
- Reset: every FSM goes to IDLE and every counter to 0. single_click, double_click and key_busy are all 0. Any key_pulse sampled while rst_n=1 is discarded. A reset in the middle of a window aborts that window with no output.
- Per-key FSM, two states: IDLE and WAIT.
  - IDLE, key_pulse[i]=1 at edge E0: go to WAIT, cnt←0, no output.
  - IDLE, key_pulse[i]=0: stay in IDLE; cnt holds at 0.
  - WAIT, key_pulse[i]=1: assert double_click[i] for one cycle (registered, high right after this edge), go to IDLE, cnt←0.
  - WAIT, key_pulse[i]=0 and cnt==CLICK_WINDOW-1: assert single_click[i] for one cycle, go to IDLE, cnt←0.
  - WAIT, otherwise: cnt←cnt+1.
- Timing: for a first event at edge E0, a second event at any edge E0+1 .. E0+CLICK_WINDOW yields double_click.
- Simultaneous timeout and event at edge E0+CLICK_WINDOW: the event wins, giving double_click and no single_click.
- Latency:
  - Double: double_click is high in the cycle after the second event's edge (1-cycle latency).
  - Single: single_click rises at edge E0+CLICK_WINDOW and stays high exactly one cycle.
- Mutual exclusion: single_click[i] and double_click[i] are never high in the same cycle, and each is never high for two consecutive cycles.
- After double_click, the key returns to IDLE. A third event starts a fresh sequence; there are no triple clicks.
- An event arriving in the same cycle that single_click is output is seen from IDLE and starts a new window.
- key_busy[i] = (state==WAIT), combinational from the state register.
- Channels are fully independent. Simultaneous events on several keys are each processed in parallel.
- Counter never exceeds CLICK_WINDOW-1 and never wraps. CLICK_WINDOW must fit in CNT_W bits.
- key_pulse held high for multiple cycles is out of contract. It is treated as successive events: cycle 1 enters WAIT, cycle 2 gives double_click.

Test Plan:
(All scenarios use CLICK_WINDOW=8.)
1. Reset: assert rst_n=1 for 3 cycles with key_pulse=3'b111 → all outputs 0, key_busy=0. After release, no click output for 20 cycles.
2. Single click: key_pulse[0] at edge E0, nothing after → key_busy[0]=1 for cycles E0..E0+7. single_click[0]=1 exactly in the cycle after edge E0+8; double_click stays 0.
3. Double click: key_pulse[1] at E0 and again at E0+3 → double_click[1]=1 in the cycle after E0+3 only; no single_click[1]; key_busy[1] drops after E0+3.
4. Window boundary:
   - Second pulse at E0+8 → double_click, not single.
   - Second pulse at E0+9 → single_click after E0+8, then a new window starts at E0+9.
5. Independence: key_pulse=3'b101 at E0, then key_pulse[2] at E0+2 → double_click[2] after E0+2; single_click[0] after E0+8; key 1 stays silent.
6. Mid-window reset: key_pulse[0] at E0, rst_n=1 at E0+4, then release → no single_click or double_click ever; key_busy[0]=0 from E0+4.

Source files
------------

// File: rtl/key_click_decoder.sv
// key_click_decoder: per-key single/double click classifier for debounced key event pulses.
// Each key runs its own IDLE/WAIT FSM with a window counter; outputs are registered one-cycle pulses.
module key_click_decoder #(
    parameter int KEY_NUM      = 3,
    parameter int CLICK_WINDOW = 15_000_000,
    parameter int CNT_W        = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_pulse,
    output logic [KEY_NUM-1:0] single_click,
    output logic [KEY_NUM-1:0] double_click,
    output logic [KEY_NUM-1:0] key_busy
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLICK_WINDOW - 1);

    genvar i;
    for (i = 0; i < KEY_NUM; i++) begin : g_key
        state_t           state, state_next;
        logic [CNT_W-1:0] cnt, cnt_next;
        logic             single_q, double_q, single_next, double_next;

        // rst_n is active-high despite its name
        always_ff @(posedge clk) begin
            if (rst_n) begin
                state    <= IDLE;
                cnt      <= '0;
                single_q <= 1'b0;
                double_q <= 1'b0;
            end else begin
                state    <= state_next;
                cnt      <= cnt_next;
                single_q <= single_next;
                double_q <= double_next;
            end
        end

        // A second event takes priority over the window expiring on the same edge
        always_comb begin
            state_next  = state;
            cnt_next    = '0;
            single_next = 1'b0;
            double_next = 1'b0;
            if (state == WAIT) begin
                if (key_pulse[i]) begin
                    double_next = 1'b1;
                    state_next  = IDLE;
                end else if (cnt == LAST) begin
                    single_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end else if (key_pulse[i]) begin
                state_next = WAIT;
            end
        end

        assign single_click[i] = single_q;
        assign double_click[i] = double_q;
        assign key_busy[i]     = (state == WAIT);
    end
endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: scoreboard bench; expected clicks are queued as {edge, key, kind} when stimulus is driven.
module tb_key_click_decoder;
    localparam int KN = 3;
    localparam int W  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [KN-1:0] key_pulse = '0;
    logic [KN-1:0] single_click, double_click, key_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] exp_q[$];

    localparam logic [1:0] SINGLE = 2'b10;
    localparam logic [1:0] DOUBLE = 2'b01;

    key_click_decoder #(.KEY_NUM(KN), .CLICK_WINDOW(W), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_pulse(key_pulse),
        .single_click(single_click),
        .double_click(double_click),
        .key_busy(key_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ent(input int c, input int k, input logic [1:0] kind);
        return {32'(c), 16'(k), 14'd0, kind};
    endfunction

    // Every output pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < KN; k++) begin
                if (single_click[k] || double_click[k]) begin
                    if (exp_q.size() == 0)
                        check("spurious", ent(cyc, k, {single_click[k], double_click[k]}), 64'd0);
                    else
                        check("click", ent(cyc, k, {single_click[k], double_click[k]}), exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input logic [KN-1:0] keys);
        key_pulse = keys;
        @(negedge clk);
        key_pulse = '0;
    endtask

    task automatic quiet_check(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            check(tag, {single_click, double_click, key_busy}, '0);
        end
    endtask

    int e0;

    initial begin
        // 1: reset with keys pressed, then silence
        key_pulse = '1;
        repeat (3) begin
            @(negedge clk);
            check("rst_out", {single_click, double_click, key_busy}, '0);
        end
        rst_n = 1'b0;
        key_pulse = '0;
        quiet_check("post_rst", 20);

        // 2: single click on key 0
        e0 = cyc + 1;
        exp_q.push_back(ent(e0 + W, 0, SINGLE));
        key_pulse = 3'b001;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            key_pulse = '0;
            check("busy0", 64'(key_busy[0]), 64'd1);
        end
        @(negedge clk);
        check("busy0_end", 64'(key_busy[0]), 64'd0);
        wait_n(5);

        // 3: double click on key 1, gap 3
        e0 = cyc + 1;
        exp_q.push_back(ent(e0 + 3, 1, DOUBLE));
        step(3'b010);
        check("busy1", 64'(key_busy[1]), 64'd1);
        wait_n(2);
        step(3'b010);
        check("busy1_end", 64'(key_busy[1]), 64'd0);
        wait_n(12);

        // 4a: second event exactly at the window edge
        e0 = cyc + 1;
        exp_q.push_back(ent(e0 + W, 2, DOUBLE));
        step(3'b100);
        wait_n(W - 1);
        step(3'b100);
        wait_n(12);

        // 4b: second event one edge late -> single, then a fresh window
        e0 = cyc + 1;
        exp_q.push_back(ent(e0 + W, 0, SINGLE));
        exp_q.push_back(ent(e0 + W + 1 + W, 0, SINGLE));
        step(3'b001);
        wait_n(W);
        step(3'b001);
        check("busy0_new", 64'(key_busy[0]), 64'd1);
        wait_n(W + 4);

        // 5: independence across keys
        e0 = cyc + 1;
        exp_q.push_back(ent(e0 + 2, 2, DOUBLE));
        exp_q.push_back(ent(e0 + W, 0, SINGLE));
        step(3'b101);
        wait_n(1);
        step(3'b100);
        check("busy_mix", 64'(key_busy), 64'b001);
        wait_n(W + 4);

        // held pulse counts as two events
        e0 = cyc + 1;
        exp_q.push_back(ent(e0 + 1, 1, DOUBLE));
        key_pulse = 3'b010;
        wait_n(2);
        key_pulse = '0;
        wait_n(12);

        // 6: reset in the middle of a window aborts it silently
        step(3'b001);
        wait_n(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", {single_click, double_click, key_busy}, '0);
        rst_n = 1'b0;
        quiet_check("abort", 15);

        check("drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
